star_bbox_finder: RTL and testbench
===================================

Name: star_bbox_finder

Overview:
- Next-generation star extent finder.
- A seed pixel (x,y) is supplied by the star detector. The block scans an external read-only frame buffer to find the star's right, left, bottom and top extents and its centre.
- Resolution, coordinate widths, pixel depth and threshold are parametrised. Left and top scans are added, plus an explicit start/busy/done handshake and a dark-seed error.
- Sits between the star detector and the star-drawing/logging FSM.

Parameters:
- X_RES, 60, frame width in pixels
- Y_RES, 60, frame height in pixels
- XW, 6, x coordinate width (>= clog2(X_RES))
- YW, 6, y coordinate width (>= clog2(Y_RES))
- AW, 12, frame-buffer address width (>= clog2(X_RES*Y_RES))
- PW, 3, pixel value width
- THRESHOLD, 0, a pixel is lit iff value > THRESHOLD (unsigned compare)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- seed_x  in  XW  seed column, latched on accepted start
- seed_y  in  YW  seed row, latched on accepted start
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  AW  read address, rd_y*X_RES + rd_x
- rd_data  in  PW  pixel value, valid exactly 1 cycle after rd_en
- busy  out  1  high from start acceptance until the done cycle, inclusive
- done  out  1  one-cycle completion pulse
- seed_dark  out  1  seed pixel was not lit; valid with done, held after
- left, right  out  XW  horizontal extents on the seed row
- top, bottom  out  YW  vertical extents on the centre column
- cx  out  XW  (left+right)>>1
- cy  out  YW  (top+bottom)>>1

Behaviour:
- Reset (async assert, sync deassert use):
  - All outputs 0, state IDLE.
  - Reset mid-scan aborts immediately; no done is produced.
- Probe: one pixel test takes 2 cycles.
  - ISSUE: rd_en=1, rd_addr is the probe address.
  - CHECK: compare rd_data.
  - rd_en is 0 in every other state.
- States:
  - IDLE: start=1 latches the seed, goes to SEED.
  - SEED: probe (sx,sy). Lit -> R. Dark -> DONE with seed_dark=1 and all extents/centre = seed.
  - R: probe x=right+1 while right < X_RES-1. Lit -> right++. Dark or at edge -> L. right is initialised to sx.
  - L: probe x=left-1 while left > 0. Lit -> left--. Dark or left==0 -> CX. left is initialised to sx.
  - CX (1 cycle): cx = (left+right)>>1 using an XW+1-bit sum. top and bottom are initialised to sy.
  - D: probe (cx, bottom+1) while bottom < Y_RES-1. Lit -> bottom++. Otherwise -> U.
  - U: probe (cx, top-1) while top > 0. Lit -> top--. Otherwise -> CY.
  - CY (1 cycle): cy = (top+bottom)>>1 using a YW+1-bit sum.
  - DONE: done=1 for one cycle, then IDLE.
- Edge handling:
  - Edge pixels are included when lit.
  - No probe is issued beyond an edge; the scan terminates without spending a read.
- Latency: done is high 2*P + 2 cycles after the start-sampling edge for a normal run (P = probes issued, including the seed), and 2 cycles for a dark seed.
- Result retention: results hold until the next accepted start. Registers update live during a scan; consumers read only at or after done.
- start while busy is ignored, with no queuing.
- start coinciding with done is ignored (busy is still 1).
- Reset values of intermediate counters do not matter; all are reloaded on start.
- Address arithmetic: rd_addr = rd_y*X_RES + rd_x, computed zero-extended to AW bits. There is no signed arithmetic.

Decomposition:
- Shared package star_pkg:
  - State enum (IDLE, SEED, R, L, CX, D, U, CY, DONE).
  - Default X_RES/Y_RES/THRESHOLD constants.
  - lit(pix) compare function.
- Sub-module pixel_addr_gen (x, y -> addr): generic multiply-by-constant, parametrised on X_RES/XW/YW/AW. It replaces the fixed 60-wide translator and is reused by the drawing FSM.
- FSM and datapath stay in one module.

Test Plan:
1. Single lit pixel at (10,10), all else 0, start:
   - Outputs: left=right=cx=10, top=bottom=cy=10, seed_dark=0.
   - P=5; done is high exactly 12 cycles after the start edge.
2. Lit rectangle x 20..24, y 30..32, seed (21,31):
   - Outputs: left=20, right=24, cx=22, top=30, bottom=32, cy=31.
   - rd_en is never high outside ISSUE cycles.
3. Star touching the corner, lit x 56..59, y 0..2, seed (57,1):
   - Outputs: right=59, top=0, left=56, bottom=2.
   - No rd_addr for x=60 or y=-1 is ever issued.
4. Dark seed (5,5):
   - Outputs: seed_dark=1, all extents 5, cx=5, cy=5.
   - done arrives 2 cycles after start, with only one read issued.
5. Handshake:
   - A second start pulsed mid-scan, and again on the done cycle: both are ignored and the results match the first seed.
   - A start one cycle after done is accepted.
6. Reset asserted during the D scan:
   - Outputs go to 0 in the same cycle (async) and no done is produced.
   - After reset deasserts, a new start completes correctly.

Source files
------------

// File: rtl/star_pkg.sv
// Shared types and helpers for the star extent finder and its frame-buffer clients.
package star_pkg;
    typedef enum logic [3:0] {
        ST_IDLE, ST_SEED, ST_R, ST_L, ST_CX, ST_D, ST_U, ST_CY, ST_DONE
    } state_t;

    localparam int DEF_X_RES     = 60;
    localparam int DEF_Y_RES     = 60;
    localparam int DEF_THRESHOLD = 0;

    function automatic logic lit(input logic [31:0] pix, input logic [31:0] thr);
        return pix > thr;
    endfunction
endpackage

// File: rtl/pixel_addr_gen.sv
// Linear frame-buffer address from (x, y): y*X_RES + x, zero-extended to AW bits.
module pixel_addr_gen #(
    parameter int X_RES = 60,
    parameter int XW    = 6,
    parameter int YW    = 6,
    parameter int AW    = 12
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [AW-1:0] addr
);
    localparam logic [AW-1:0] ROW = AW'(X_RES);

    assign addr = AW'(y) * ROW + AW'(x);
endmodule

// File: rtl/star_bbox_finder.sv
// Scans the frame buffer outward from a lit seed to find the star's extents and centre.
module star_bbox_finder
    import star_pkg::*;
#(
    parameter int X_RES     = DEF_X_RES,
    parameter int Y_RES     = DEF_Y_RES,
    parameter int XW        = 6,
    parameter int YW        = 6,
    parameter int AW        = 12,
    parameter int PW        = 3,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] seed_x,
    input  logic [YW-1:0] seed_y,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [PW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          seed_dark,
    output logic [XW-1:0] left,
    output logic [XW-1:0] right,
    output logic [YW-1:0] top,
    output logic [YW-1:0] bottom,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy
);
    state_t        st, stNext;
    logic          ph, phNext;          // 0: ISSUE, 1: CHECK
    logic [XW-1:0] sx, sy_x_unused_guard;
    logic [YW-1:0] sy;
    logic [XW-1:0] nSx, nLeft, nRight, nCx;
    logic [YW-1:0] nSy, nTop, nBottom, nCy;
    logic          nSeedDark;
    logic          goR, goL, goD, goU;
    logic          pixLit;
    logic [XW:0]   cxSum;
    logic [YW:0]   cySum;
    logic [XW-1:0] rdX;
    logic [YW-1:0] rdY;

    assign sy_x_unused_guard = '0;
    assign pixLit = lit(32'(rd_data), 32'(THRESHOLD));
    assign cxSum  = {1'b0, left} + {1'b0, right};
    assign cySum  = {1'b0, top} + {1'b0, bottom};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= ST_IDLE;
            ph        <= 1'b0;
            sx        <= '0;
            sy        <= '0;
            left      <= '0;
            right     <= '0;
            top       <= '0;
            bottom    <= '0;
            cx        <= '0;
            cy        <= '0;
            seed_dark <= 1'b0;
        end else begin
            st        <= stNext;
            ph        <= phNext;
            sx        <= nSx;
            sy        <= nSy;
            left      <= nLeft;
            right     <= nRight;
            top       <= nTop;
            bottom    <= nBottom;
            cx        <= nCx;
            cy        <= nCy;
            seed_dark <= nSeedDark;
        end
    end

    always_comb begin
        stNext    = st;
        phNext    = 1'b0;
        nSx       = sx;
        nSy       = sy;
        nLeft     = left;
        nRight    = right;
        nTop      = top;
        nBottom   = bottom;
        nCx       = cx;
        nCy       = cy;
        nSeedDark = seed_dark;
        goR       = 1'b0;
        goL       = 1'b0;
        goD       = 1'b0;
        goU       = 1'b0;

        case (st)
            ST_IDLE: if (start) begin
                nSx       = seed_x;
                nSy       = seed_y;
                nLeft     = seed_x;
                nRight    = seed_x;
                nCx       = seed_x;
                nTop      = seed_y;
                nBottom   = seed_y;
                nCy       = seed_y;
                nSeedDark = 1'b0;
                stNext    = ST_SEED;
            end
            ST_SEED: begin
                if (!ph) phNext = 1'b1;
                else if (pixLit) goR = 1'b1;
                else begin
                    nSeedDark = 1'b1;
                    stNext    = ST_DONE;
                end
            end
            ST_R: begin
                if (!ph) phNext = 1'b1;
                else if (pixLit) begin
                    nRight = right + XW'(1);
                    goR    = 1'b1;
                end else goL = 1'b1;
            end
            ST_L: begin
                if (!ph) phNext = 1'b1;
                else if (pixLit) begin
                    nLeft = left - XW'(1);
                    goL   = 1'b1;
                end else stNext = ST_CX;
            end
            ST_CX: begin
                nCx     = cxSum[XW:1];
                nTop    = sy;
                nBottom = sy;
                goD     = 1'b1;
            end
            ST_D: begin
                if (!ph) phNext = 1'b1;
                else if (pixLit) begin
                    nBottom = bottom + YW'(1);
                    goD     = 1'b1;
                end else goU = 1'b1;
            end
            ST_U: begin
                if (!ph) phNext = 1'b1;
                else if (pixLit) begin
                    nTop = top - YW'(1);
                    goU  = 1'b1;
                end else stNext = ST_CY;
            end
            ST_CY: begin
                nCy    = cySum[YW:1];
                stNext = ST_DONE;
            end
            ST_DONE: stNext = ST_IDLE;
            default: stNext = ST_IDLE;
        endcase

        // A scan already at the frame edge falls through to the next one without spending a read.
        if (goR) begin
            if (int'(nRight) < X_RES - 1) stNext = ST_R;
            else goL = 1'b1;
        end
        if (goL) stNext = (nLeft != '0) ? ST_L : ST_CX;
        if (goD) begin
            if (int'(nBottom) < Y_RES - 1) stNext = ST_D;
            else goU = 1'b1;
        end
        if (goU) stNext = (nTop != '0) ? ST_U : ST_CY;
    end

    always_comb begin
        rdX = '0;
        rdY = '0;
        case (st)
            ST_SEED: begin rdX = sx;             rdY = sy;              end
            ST_R:    begin rdX = right + XW'(1); rdY = sy;              end
            ST_L:    begin rdX = left - XW'(1);  rdY = sy;              end
            ST_D:    begin rdX = cx;             rdY = bottom + YW'(1); end
            ST_U:    begin rdX = cx;             rdY = top - YW'(1);    end
            default: ;
        endcase
    end

    assign rd_en = !ph && (st == ST_SEED || st == ST_R || st == ST_L ||
                           st == ST_D || st == ST_U);
    assign busy  = (st != ST_IDLE);
    assign done  = (st == ST_DONE);

    pixel_addr_gen #(.X_RES(X_RES), .XW(XW), .YW(YW), .AW(AW)) uAddr (
        .x    (rdX),
        .y    (rdY),
        .addr (rd_addr)
    );
endmodule

// File: tb/tb_star_bbox_finder.sv
// Directed bench for star_bbox_finder: frame model, scoreboard of expected results, latency/read checks.
module tb_star_bbox_finder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  seed_x = '0;
    logic [5:0]  seed_y = '0;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [2:0]  rd_data = '0;
    logic        busy, done, seed_dark;
    logic [5:0]  left, right, cx;
    logic [5:0]  top, bottom, cy;

    typedef struct {
        int l, r, t, b, cx, cy, dark, lat, reads;
    } exp_t;

    exp_t expQ[$];
    logic [2:0] fb [3600];
    int passed = 0;
    int total  = 0;

    star_bbox_finder dut (
        .clk(clk), .reset(reset), .start(start), .seed_x(seed_x), .seed_y(seed_y),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .seed_dark(seed_dark), .left(left), .right(right), .top(top), .bottom(bottom),
        .cx(cx), .cy(cy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= (rd_addr < 12'd3600) ? fb[rd_addr] : 3'd0;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic fillRect(input int x0, input int x1, input int y0, input int y1, input logic [2:0] v);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                fb[y*60 + x] = v;
    endtask

    task automatic expect_res(input int l, input int r, input int t, input int b,
                              input int dark, input int lat, input int reads);
        exp_t e;
        e.l = l; e.r = r; e.t = t; e.b = b;
        e.cx = (l + r) / 2; e.cy = (t + b) / 2;
        e.dark = dark; e.lat = lat; e.reads = reads;
        expQ.push_back(e);
    endtask

    // injK: cycle index for an extra start pulse (-1 none); rstK: cycle to assert reset (-1 none)
    task automatic run(input string tag, input int sxv, input int syv, input int injK,
                       input bit startOnDone, input int rstK);
        int reads, viol, bad, lat;
        bit prevEn;
        exp_t e;
        reads = 0; viol = 0; bad = 0; lat = -1; prevEn = 1'b0;
        seed_x = 6'(sxv);
        seed_y = 6'(syv);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        seed_x = 6'd0;
        seed_y = 6'd0;
        for (int k = 0; k <= 300; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (k == rstK) begin
                reset = 1'b1;
                #1;
                chk({tag, ".rstOut"}, int'({busy, done, seed_dark, left, right, top, bottom, cx, cy}), 0);
                for (int j = 0; j < 4; j++) begin
                    @(posedge clk); #1;
                    if (done) viol++;
                end
                @(negedge clk);
                reset = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); #1;
                    if (done || busy) viol++;
                end
                chk({tag, ".noDoneAfterRst"}, viol, 0);
                return;
            end
            if (!busy) viol++;
            if (rd_en) begin
                reads++;
                if (prevEn) viol++;
                if (rd_addr >= 12'd3600) bad++;
            end
            prevEn = rd_en;
            if (done) begin
                lat = k;
                break;
            end
            if (k == injK) start = 1'b1;
        end
        if (lat < 0) begin
            chk({tag, ".timeout"}, 0, 1);
            void'(expQ.pop_front());
            return;
        end
        e = expQ.pop_front();
        chk({tag, ".left"}, int'(left), e.l);
        chk({tag, ".right"}, int'(right), e.r);
        chk({tag, ".top"}, int'(top), e.t);
        chk({tag, ".bottom"}, int'(bottom), e.b);
        chk({tag, ".cx"}, int'(cx), e.cx);
        chk({tag, ".cy"}, int'(cy), e.cy);
        chk({tag, ".dark"}, int'(seed_dark), e.dark);
        chk({tag, ".latency"}, lat, e.lat);
        chk({tag, ".reads"}, reads, e.reads);
        chk({tag, ".protocol"}, viol, 0);
        chk({tag, ".badAddr"}, bad, 0);
        if (startOnDone) begin
            seed_x = 6'd10;
            seed_y = 6'd10;
            start  = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".postDone"}, int'({busy, done}), 0);
        chk({tag, ".hold.left"}, int'(left), e.l);
    endtask

    initial begin
        for (int i = 0; i < 3600; i++) fb[i] = 3'd0;
        fb[10*60 + 10] = 3'd5;
        fillRect(20, 24, 30, 32, 3'd3);
        fillRect(56, 59, 0, 2, 3'd7);

        #12;
        chk("reset.outs", int'({busy, done, seed_dark, rd_en, left, right, top, bottom, cx, cy}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle.busy", int'(busy), 0);

        expect_res(10, 10, 10, 10, 0, 12, 5);
        run("single", 10, 10, -1, 1'b0, -1);

        expect_res(20, 24, 30, 32, 0, 24, 11);
        run("rect", 21, 31, -1, 1'b0, -1);

        expect_res(56, 59, 0, 2, 0, 18, 8);
        run("corner", 57, 1, -1, 1'b0, -1);

        expect_res(5, 5, 5, 5, 1, 2, 1);
        run("dark", 5, 5, -1, 1'b0, -1);

        // Extra starts mid-scan and on the done cycle must both be ignored.
        expect_res(20, 24, 30, 32, 0, 24, 11);
        seed_x = 6'd10;
        run("hsIgnore", 21, 31, 5, 1'b1, -1);

        // Start one cycle after done is accepted.
        expect_res(10, 10, 10, 10, 0, 12, 5);
        run("hsNext", 10, 10, -1, 1'b0, -1);

        run("abort", 10, 10, -1, 1'b0, 7);

        expect_res(20, 24, 30, 32, 0, 24, 11);
        run("afterRst", 21, 31, -1, 1'b0, -1);

        chk("scoreboard.empty", expQ.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
